// File: rtl/result_byte_tx_pkg.sv
// Shared definitions for the byte-wise operand/result path: tag codes, byte width
// and the transmit state encoding.
package result_byte_tx_pkg;

  localparam int BYTE_W = 8;

  // Tag codes shown on the display next to the byte index ("A1", "C4", ...).
  localparam logic [3:0] TAG_A = 4'hA;
  localparam logic [3:0] TAG_B = 4'hB;
  localparam logic [3:0] TAG_R = 4'hC;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_CHK,
    TX_FIN
  } tx_state_t;

endpackage

// File: rtl/result_byte_tx_byte_sel.sv
// Combinational byte mux: picks byte number idx (1-based) out of a word, either
// from the bottom (MSB_FIRST=0) or from the top (MSB_FIRST=1). Out-of-range idx gives 0.
module result_byte_tx_byte_sel
  import result_byte_tx_pkg::*;
#(
  parameter int NBYTES    = 4,
  parameter int MSB_FIRST = 0,
  parameter int IDX_W     = 3
) (
  input  logic [BYTE_W*NBYTES-1:0] word,
  input  logic [IDX_W-1:0]         idx,
  output logic [BYTE_W-1:0]        sel
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sel = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IDX_W'(i + 1)) begin
        sel = (MSB_FIRST != 0) ? word[(NBYTES-1-i)*BYTE_W +: BYTE_W]
                               : word[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/result_byte_tx.sv
// Serializes a tagged word onto an 8-bit valid/ready byte bus, one byte per handshake.
// Define RESULT_BYTE_TX_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module result_byte_tx
  import result_byte_tx_pkg::*;
#(
  parameter int NBYTES    = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BYTE_W*NBYTES-1:0] word_in,
  input  logic [3:0]               tag_in,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic [BYTE_W-1:0]        byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [2:0]               byte_idx,
  output logic [3:0]               tag_out,
  output logic                     busy,
  output logic                     done
);

  localparam int               CNT_W = $clog2(NBYTES + 2);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NBYTES);

  tx_state_t                state, state_d;
  logic [CNT_W-1:0]         cnt, cnt_d;
  logic [BYTE_W*NBYTES-1:0] word_q;
  logic [3:0]               tag_q;
  logic                     load_fire;
  logic [BYTE_W-1:0]        data_byte;

  result_byte_tx_byte_sel #(
    .NBYTES    (NBYTES),
    .MSB_FIRST (MSB_FIRST),
    .IDX_W     (CNT_W)
  ) u_byte_sel (
    .word (word_q),
    .idx  (cnt),
    .sel  (data_byte)
  );

`ifdef RESULT_BYTE_TX_CHECKSUM_EN
  logic [BYTE_W-1:0] chk_byte;

  always_comb begin
    chk_byte = '0;
    for (int i = 0; i < NBYTES; i++) chk_byte ^= word_q[i*BYTE_W +: BYTE_W];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state  <= TX_IDLE;
      cnt    <= '0;
      word_q <= '0;
      tag_q  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (load_fire) begin
        word_q <= word_in;
        tag_q  <= tag_in;
      end
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    load_fire  = 1'b0;
    load_ready = 1'b0;
    byte_valid = 1'b0;
    byte_out   = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      TX_IDLE: begin
        load_ready = 1'b1;
        busy       = 1'b0;
        if (load_valid) begin
          load_fire = 1'b1;
          cnt_d     = CNT_W'(1);
          state_d   = TX_SEND;
        end
      end
      TX_SEND: begin
        byte_valid = 1'b1;
        byte_out   = data_byte;
        if (byte_ready) begin
          if (cnt == LAST) begin
`ifdef RESULT_BYTE_TX_CHECKSUM_EN
            cnt_d   = cnt + CNT_W'(1);
            state_d = TX_CHK;
`else
            state_d = TX_FIN;
`endif
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
`ifdef RESULT_BYTE_TX_CHECKSUM_EN
      TX_CHK: begin
        byte_valid = 1'b1;
        byte_out   = chk_byte;
        if (byte_ready) state_d = TX_FIN;
      end
`endif
      TX_FIN: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = TX_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = TX_IDLE;
      end
    endcase
  end

  assign byte_idx = 3'(cnt);
  assign tag_out  = tag_q;

endmodule

// File: tb/tb_result_byte_tx.sv
// Self-checking bench for result_byte_tx: LSB-first and MSB-first instances run in
// lockstep against directed vectors, hand-written corner sequences and random words.
module tb_result_byte_tx;
  import result_byte_tx_pkg::*;

  localparam int NBYTES = 4;
`ifdef RESULT_BYTE_TX_CHECKSUM_EN
  localparam int N_OUT = NBYTES + 1;
`else
  localparam int N_OUT = NBYTES;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] word_in = '0;
  logic [3:0]  tag_in = '0;
  logic        load_valid = 1'b0;
  logic        byte_ready = 1'b0;

  logic       load_ready_l, byte_valid_l, busy_l, done_l;
  logic [7:0] byte_out_l;
  logic [2:0] byte_idx_l;
  logic [3:0] tag_out_l;
  logic       load_ready_m, byte_valid_m, busy_m, done_m;
  logic [7:0] byte_out_m;
  logic [2:0] byte_idx_m;
  logic [3:0] tag_out_m;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  result_byte_tx #(.NBYTES(NBYTES), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .word_in(word_in), .tag_in(tag_in),
    .load_valid(load_valid), .load_ready(load_ready_l), .byte_out(byte_out_l),
    .byte_valid(byte_valid_l), .byte_ready(byte_ready), .byte_idx(byte_idx_l),
    .tag_out(tag_out_l), .busy(busy_l), .done(done_l)
  );

  result_byte_tx #(.NBYTES(NBYTES), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .word_in(word_in), .tag_in(tag_in),
    .load_valid(load_valid), .load_ready(load_ready_m), .byte_out(byte_out_m),
    .byte_valid(byte_valid_m), .byte_ready(byte_ready), .byte_idx(byte_idx_m),
    .tag_out(tag_out_m), .busy(busy_m), .done(done_m)
  );

  typedef struct {
    logic [31:0] word;
    logic [3:0]  tag;
    logic [31:0] seq_lsb;  // transmitted bytes, first byte in [31:24]
    logic [31:0] seq_msb;
    logic [7:0]  chk;
    int          stall_idx;
    int          stall_len;
    bit          poke;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte k of a word by plain shifting, checksum by XOR of all bytes.
  function automatic void model_seq(input logic [31:0] w, output logic [31:0] sl,
                                    output logic [31:0] sm, output logic [7:0] c);
    sl = '0;
    sm = '0;
    c  = '0;
    for (int k = 1; k <= NBYTES; k++) begin
      sl[31-8*(k-1) -: 8] = 8'(w >> (8 * (k - 1)));
      sm[31-8*(k-1) -: 8] = 8'(w >> (8 * (NBYTES - k)));
      c ^= 8'(w >> (8 * (k - 1)));
    end
  endfunction

  task automatic check_byte(input int k, input logic [7:0] el, input logic [7:0] em,
                            input logic [3:0] t);
    check($sformatf("valid_l[%0d]", k), 32'(byte_valid_l), 1);
    check($sformatf("valid_m[%0d]", k), 32'(byte_valid_m), 1);
    check($sformatf("byte_l[%0d]", k), 32'(byte_out_l), 32'(el));
    check($sformatf("byte_m[%0d]", k), 32'(byte_out_m), 32'(em));
    check($sformatf("idx_l[%0d]", k), 32'(byte_idx_l), k);
    check($sformatf("idx_m[%0d]", k), 32'(byte_idx_m), k);
    check($sformatf("tag[%0d]", k), 32'(tag_out_l), 32'(t));
    check($sformatf("busy_ld_done[%0d]", k), {29'd0, busy_l, load_ready_l, done_l}, 32'b100);
  endtask

  // Called at a negedge with both DUTs idle; returns at a negedge with both idle again.
  task automatic run_word(input logic [31:0] w, input logic [3:0] t, input logic [31:0] sl,
                          input logic [31:0] sm, input logic [7:0] c, input int st_idx,
                          input int st_len, input bit poke, input bit rnd);
    int         stall;
    logic [7:0] el, em;
    check("load_ready_idle", {30'd0, load_ready_l, load_ready_m}, 32'b11);
    load_valid = 1'b1;
    word_in    = w;
    tag_in     = t;
    byte_ready = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    word_in    = $urandom;
    tag_in     = 4'($urandom);
    for (int k = 1; k <= N_OUT; k++) begin
      if (k <= NBYTES) begin
        el = sl[31-8*(k-1) -: 8];
        em = sm[31-8*(k-1) -: 8];
      end else begin
        el = c;
        em = c;
      end
      stall = rnd ? int'($urandom_range(0, 3)) : ((k == st_idx) ? st_len : 0);
      for (int s = 0; s <= stall; s++) begin
        check_byte(k, el, em, t);
        byte_ready = (s == stall);
        if (poke && k == 2) begin
          load_valid = (s < stall);
          word_in    = 32'hDEADBEEF;
          tag_in     = TAG_A;
        end
        @(negedge clk);
      end
    end
    byte_ready = 1'b0;
    load_valid = 1'b0;
    check("fin_done", {30'd0, done_l, done_m}, 32'b11);
    check("fin_valid", {30'd0, byte_valid_l, byte_valid_m}, 32'b00);
    check("fin_load_ready", {30'd0, load_ready_l, load_ready_m}, 32'b00);
    @(negedge clk);
    check("post_done", {30'd0, done_l, done_m}, 32'b00);
    check("post_idle", {29'd0, busy_l, load_ready_l, byte_valid_l}, 32'b010);
  endtask

  initial begin
    logic [31:0] w, sl, sm;
    logic [7:0]  c;
    logic [3:0]  t;

    vecs[0] = '{32'h3FC00000, TAG_R, 32'h0000C03F, 32'h3FC00000, 8'hFF, 0, 0, 1'b0};
    vecs[1] = '{32'h12345678, TAG_R, 32'h78563412, 32'h12345678, 8'h08, 2, 5, 1'b0};
    vecs[2] = '{32'hA1B2C3D4, TAG_B, 32'hD4C3B2A1, 32'hA1B2C3D4, 8'h04, 2, 3, 1'b1};
    vecs[3] = '{32'h11223344, TAG_A, 32'h44332211, 32'h11223344, 8'h44, 1, 2, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_load_ready", {30'd0, load_ready_l, load_ready_m}, 32'b11);
    check("rst_valid_busy_done", {29'd0, byte_valid_l, busy_l, done_l}, 32'b000);
    check("rst_byte_out", 32'(byte_out_l), 0);
    check("rst_byte_idx", 32'(byte_idx_l), 0);
    check("rst_tag_out", 32'(tag_out_l), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_rst", {30'd0, load_ready_l, busy_l}, 32'b10);

    // Directed vectors: plain stream, backpressure, ignored load, stall on byte 1
    foreach (vecs[i]) begin
      run_word(vecs[i].word, vecs[i].tag, vecs[i].seq_lsb, vecs[i].seq_msb, vecs[i].chk,
               vecs[i].stall_idx, vecs[i].stall_len, vecs[i].poke, 1'b0);
      @(negedge clk);
    end

    // Reset asserted while byte 3 is on the bus aborts the word
    load_valid = 1'b1;
    word_in    = 32'h12345678;
    tag_in     = TAG_R;
    byte_ready = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_idx3", 32'(byte_idx_l), 3);
    check("abort_byte3", 32'(byte_out_l), 32'h34);
    byte_ready = 1'b0;
    reset      = 1'b1;
    #1;
    check("abort_valid", {30'd0, byte_valid_l, byte_valid_m}, 32'b00);
    check("abort_load_ready", {30'd0, load_ready_l, load_ready_m}, 32'b11);
    check("abort_busy_done", {30'd0, busy_l, done_l}, 32'b00);
    check("abort_idx", 32'(byte_idx_l), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_no_done[%0d]", i), {30'd0, done_l, done_m}, 32'b00);
    end
    run_word(vecs[0].word, vecs[0].tag, vecs[0].seq_lsb, vecs[0].seq_msb, vecs[0].chk,
             0, 0, 1'b0, 1'b0);

    // Random words with random per-byte backpressure against the model
    for (int n = 0; n < 20; n++) begin
      w = $urandom;
      case ($urandom_range(0, 2))
        0:       t = TAG_A;
        1:       t = TAG_B;
        default: t = TAG_R;
      endcase
      model_seq(w, sl, sm, c);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      run_word(w, t, sl, sm, c, 0, 0, 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/result_byte_tx.md
Name: result_byte_tx

Overview:
- Transmit side of the byte-wise operand/result path: takes one 32-bit word plus a tag and serializes it onto an 8-bit byte bus, one byte per valid/ready handshake.
- Sits after the floating-point multiplier. Streams the product (tag C) or an echoed operand (tags A/B) toward the display/byte sink.
- Each byte carries a 1-based index and the tag, so the sink can show "C1".."C4" directly.

Parameters:
- NBYTES, 4, number of bytes per word; word width is 8*NBYTES.
- MSB_FIRST, 0, 0 = byte 1 is bits [7:0] (matches input collection order); 1 = byte 1 is the top byte.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- word_in  in  8*NBYTES  word to send; sampled only on load handshake.
- tag_in  in  4  display tag code (A=4'hA, B=4'hB, R=4'hC); sampled with word_in.
- load_valid  in  1  producer offers word_in/tag_in.
- load_ready  out  1  high in IDLE only.
- byte_out  out  8  current byte.
- byte_valid  out  1  byte_out/byte_idx/tag_out valid.
- byte_ready  in  1  sink accepts current byte.
- byte_idx  out  3  1-based byte number (1..NBYTES; NBYTES+1 for checksum when enabled).
- tag_out  out  4  registered copy of tag_in.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse after last byte accepted.

Behaviour:
- Reset values:
  - load_ready=1, byte_valid=0, byte_out=0, byte_idx=0, tag_out=0, busy=0, done=0.
  - Shift register and counter clear; state IDLE.
  - Reset asserted mid-word aborts the transfer: no done pulse, partial word discarded.
- States: IDLE, SEND, CHK (only with CHECKSUM_EN), FIN.
- IDLE:
  - load_ready=1.
  - On load_valid & load_ready: latch word and tag, counter=1, go SEND.
  - byte_valid rises on the next cycle with byte 1 (one-cycle latency from load).
- SEND:
  - byte_valid=1.
  - byte_out = byte selected by counter and MSB_FIRST.
  - byte_idx = counter.
  - Outputs stay stable while byte_ready=0; the sink may hold ready low indefinitely.
  - On byte_valid & byte_ready, counter<NBYTES: counter+1, next byte presented in the following cycle with no bubble.
  - On byte_valid & byte_ready, counter==NBYTES: go CHK if enabled, else FIN.
- CHK: byte_out = XOR of all NBYTES bytes; byte_idx=NBYTES+1; handshake same as SEND; then FIN.
- FIN:
  - byte_valid=0, done=1 for exactly one cycle, then IDLE.
  - load_ready is low in FIN, so back-to-back words need at least one idle cycle between last byte and next load.
- load_valid outside IDLE is ignored; word_in may change freely after the load handshake.
- byte_ready while byte_valid=0 has no effect.
- Counter width is clog2(NBYTES+2). With NBYTES=4 the maximum byte_idx is 5, with no wrap-around.
- Throughput: NBYTES (+1) accepted bytes + 2 overhead cycles per word when byte_ready is held high.

Optional Feature:
- Macro: RESULT_BYTE_TX_CHECKSUM_EN.
- Defined: CHK state exists; an XOR checksum byte (byte_idx=NBYTES+1) follows the data bytes before done.
- Undefined: no CHK state; done follows the last data byte; byte_idx never exceeds NBYTES.

Decomposition:
- Shared package holds:
  - tag codes TAG_A=4'hA, TAG_B=4'hB, TAG_R=4'hC (also used by the input collector's display);
  - the tx state enum;
  - BYTE_W=8.
- One natural sub-module: byte_sel, the combinational byte mux (word, index, MSB_FIRST -> byte). Keep it reusable for the display path.

Test Plan:
- Reset, then load word_in=32'h3FC00000, tag_in=4'hC, byte_ready=1 -> bytes 00,00,C0,3F with idx 1..4 on consecutive cycles, tag_out=C, done one cycle after idx 4.
- Same word with MSB_FIRST=1 -> bytes 3F,C0,00,00.
- Backpressure: byte_ready low for 5 cycles during idx 2 of 32'h12345678 -> byte_out stays 8'h56 and idx stays 2 throughout; afterwards 34,12 follow with no loss or duplication.
- load_valid pulsed while busy with word 32'hDEADBEEF -> ignored; the original stream completes unchanged.
- Reset asserted during idx 3 -> next cycle byte_valid=0, load_ready=1, no done; a fresh load then restarts at idx 1.
- CHECKSUM_EN, word 32'h11223344 -> fifth byte idx 5 = 8'h44 (11^22^33^44), then done.
